// File: rtl/fp_result_narrow.sv
// rtl/fp_result_narrow.sv - two-stage narrowing of divsqrt double results to NaN-boxed single
// S1 holds the raw result; S2 holds the packed word and narrowing flags that drive out_*.
module fp_result_narrow #(
  parameter int TAG_W  = 4,
  parameter bit NANBOX = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_p,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_of,
  output logic             out_uf,
  output logic             out_nx
);

  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_data_q;
  logic             s1_p_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [63:0]      s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_of_q, s2_uf_q, s2_nx_q;
  logic             s2_of_d, s2_uf_d, s2_nx_d;

  logic        s2_adv, s1_adv, accept;
  logic        sgn;
  logic [10:0] exp_d;
  logic [51:0] man;
  logic [7:0]  exp_s;
  logic [31:0] lo;
  logic        n_of, n_uf, n_nx;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_adv;
  assign in_ready = reset_n & (~s1_valid_q | s2_adv);
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)      s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
  end

  // Single exponent rebias: e - 896, and 896 is 128 modulo 256.
  assign sgn   = s1_data_q[63];
  assign exp_d = s1_data_q[62:52];
  assign man   = s1_data_q[51:0];
  assign exp_s = exp_d[7:0] - 8'd128;

  always_comb begin
    lo   = {sgn, 31'b0};
    n_of = 1'b0;
    n_uf = 1'b0;
    n_nx = 1'b0;
    if (exp_d == 11'h7FF) begin
      lo = (man != 52'd0) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'b0};
    end else if (exp_d == 11'd0) begin
      n_uf = (man != 52'd0);
      n_nx = (man != 52'd0);
    end else if (exp_d > 11'd1150) begin
      lo   = {sgn, 8'hFF, 23'b0};
      n_of = 1'b1;
      n_nx = 1'b1;
    end else if (exp_d < 11'd897) begin
      n_uf = 1'b1;
      n_nx = 1'b1;
    end else begin
      lo   = {sgn, exp_s, man[51:29]};
      n_nx = |man[28:0];
    end
  end

  always_comb begin
    s2_data_d = s1_data_q;
    s2_of_d   = 1'b0;
    s2_uf_d   = 1'b0;
    s2_nx_d   = 1'b0;
    if (s1_p_q) begin
      s2_data_d = {{32{NANBOX}}, lo};
      s2_of_d   = n_of;
      s2_uf_d   = n_uf;
      s2_nx_d   = n_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_p_q     <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_of_q    <= 1'b0;
      s2_uf_q    <= 1'b0;
      s2_nx_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_data_q <= in_data;
        s1_p_q    <= in_p;
        s1_tag_q  <= in_tag;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_tag_q  <= s1_tag_q;
          s2_of_q   <= s2_of_d;
          s2_uf_q   <= s2_uf_d;
          s2_nx_q   <= s2_nx_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_of    = s2_of_q;
  assign out_uf    = s2_uf_q;
  assign out_nx    = s2_nx_q;

endmodule

// File: tb/tb_fp_result_narrow.sv
// tb/tb_fp_result_narrow.sv - scoreboard bench for fp_result_narrow (NANBOX=1 and NANBOX=0)
module tb_fp_result_narrow;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        of, uf, nx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_p = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, of_a, uf_a, nx_a;
  logic [63:0] out_data_a;
  logic [3:0]  out_tag_a;
  logic        in_ready_b, out_valid_b, of_b, uf_b, nx_b;
  logic [63:0] out_data_b;
  logic [3:0]  out_tag_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [63:0] prev_data_a, prev_data_b;
  logic [3:0]  prev_tag_a, prev_tag_b;

  fp_result_narrow #(.TAG_W(4), .NANBOX(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_p(in_p), .in_tag(in_tag), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_tag(out_tag_a),
    .out_of(of_a), .out_uf(uf_a), .out_nx(nx_a)
  );

  fp_result_narrow #(.TAG_W(4), .NANBOX(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_p(in_p), .in_tag(in_tag), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_tag(out_tag_b),
    .out_of(of_b), .out_uf(uf_b), .out_nx(nx_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [63:0] d, input logic [3:0] t,
                     input logic o, input logic u, input logic n);
    exp_t e;
    if (!(v && out_ready)) return;
    if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out dut%0d: got tag %h data %h, nothing expected", id, t, d);
      return;
    end
    e = (id == 0) ? qa.pop_front() : qb.pop_front();
    chk(id == 0 ? "data_a" : "data_b", d, e.data);
    chk(id == 0 ? "tag_a" : "tag_b", {60'd0, t}, {60'd0, e.tag});
    chk(id == 0 ? "flags_a" : "flags_b", {61'd0, o, u, n}, {61'd0, e.of, e.uf, e.nx});
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        chk("hold_data_a", out_data_a, prev_data_a);
        chk("hold_tag_a", {60'd0, out_tag_a}, {60'd0, prev_tag_a});
      end
      if (stall_b) chk("hold_data_b", out_data_b, prev_data_b);
      mon(0, out_valid_a, out_data_a, out_tag_a, of_a, uf_a, nx_a);
      mon(1, out_valid_b, out_data_b, out_tag_b, of_b, uf_b, nx_b);
      stall_a = out_valid_a && !out_ready;
      stall_b = out_valid_b && !out_ready;
      prev_data_a = out_data_a;
      prev_tag_a  = out_tag_a;
      prev_data_b = out_data_b;
      prev_tag_b  = out_tag_b;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted.
  task automatic send(input logic [63:0] d, input logic p, input logic [3:0] t,
                      input logic [31:0] lo, input logic o, input logic u, input logic n);
    exp_t ea, eb;
    logic acc;
    int   waited;
    ea.tag = t; ea.of = o; ea.uf = u; ea.nx = n;
    ea.data = p ? {32'hFFFF_FFFF, lo} : d;
    eb = ea;
    eb.data = p ? {32'h0, lo} : d;
    in_valid = 1'b1; in_data = d; in_p = p; in_tag = t;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (acc) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %h not accepted within %0d cycles", t, waited);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready_a}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("reset_out_data", out_data_a, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic single with latency check
    send(64'h3FF0_0000_0000_0000, 1'b1, 4'd5, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_cycle1", {63'd0, out_valid_a}, 64'd0);
    @(negedge clk);
    chk("latency_cycle2", {63'd0, out_valid_a}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back
    send(64'h4009_21FB_5444_2D18, 1'b0, 4'd6, 32'h0,         1'b0, 1'b0, 1'b0);
    send(64'h3FF0_0000_0000_0001, 1'b1, 4'd7, 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    send(64'h47F0_0000_0000_0000, 1'b1, 4'd8, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    send(64'hB800_0000_0000_0000, 1'b1, 4'd9, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    send(64'h3810_0000_0000_0000, 1'b1, 4'hA, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    send(64'h47E0_0000_0000_0000, 1'b1, 4'hB, 32'h7F00_0000, 1'b0, 1'b0, 1'b0);
    send(64'h7FF8_0000_0000_0001, 1'b1, 4'hC, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);
    send(64'hFFF0_0000_0000_0000, 1'b1, 4'hD, 32'hFF80_0000, 1'b0, 1'b0, 1'b0);
    send(64'hFFF8_0000_0000_0000, 1'b1, 4'hE, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 1'b1, 4'hF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    send(64'h0000_0000_0000_0001, 1'b1, 4'h1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    send(64'h3FF8_0000_0000_0000, 1'b1, 4'h2, 32'h3FC0_0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two held, third refused
    out_ready = 1'b0;
    send(64'h3FF0_0000_0000_0000, 1'b1, 4'd1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    send(64'h4000_0000_0000_0000, 1'b1, 4'd2, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 64'hC000_0000_0000_0000; in_p = 1'b1; in_tag = 4'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready_a}, 64'd0);
      chk("bp_out_tag", {60'd0, out_tag_a}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'hC000_0000_0000_0000, 1'b1, 4'd3, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_drain_tag2", {59'd0, out_valid_a, out_tag_a}, {59'd0, 1'b1, 4'd2});
    @(negedge clk);
    chk("bp_drain_tag3", {59'd0, out_valid_a, out_tag_a}, {59'd0, 1'b1, 4'd3});
    @(posedge clk); #1;

    // Reset while two entries are stalled
    out_ready = 1'b0;
    send(64'h3FF0_0000_0000_0000, 1'b1, 4'd4, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    send(64'h3FF0_0000_0000_0000, 1'b1, 4'd5, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready_a}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_out_data", out_data_a, 64'd0);
    chk("rst_out_tag_flags", {57'd0, out_tag_a, of_a, uf_a, nx_a}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'hBFF0_0000_0000_0000, 1'b1, 4'd9, 32'hBF80_0000, 1'b0, 1'b0, 1'b0);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(qa.size() + qb.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
